// File: rtl/cv32e40p_mult_sched_ft_if.sv
// Handshake and status bundle between the EX-stage multiply issue logic,
// the redundancy scheduler and the replicated MULT units with their voter.
interface cv32e40p_mult_sched_ft_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [1:0]  req_class_i;
  logic [11:0] permanent_faulty_mult_i;
  logic [2:0]  mult_enable_o;
  logic [2:0]  mult_ready_i;
  logic        mismatch_i;
  logic [1:0]  mode_o;
  logic [1:0]  sel_o;
  logic        done_o;
  logic        done_err_o;
  logic [31:0] retry_count_o;

  // Scheduler side
  modport slave (
    input  req_valid_i, req_class_i, permanent_faulty_mult_i, mult_ready_i, mismatch_i,
    output req_ready_o, mult_enable_o, mode_o, sel_o, done_o, done_err_o, retry_count_o
  );

  // Requester / MULT-unit side
  modport master (
    output req_valid_i, req_class_i, permanent_faulty_mult_i, mult_ready_i, mismatch_i,
    input  req_ready_o, mult_enable_o, mode_o, sel_o, done_o, done_err_o, retry_count_o
  );
endinterface

// File: rtl/cv32e40p_mult_sched_ft.sv
// Fault-tolerant multiply scheduler: picks TMR/DMR/simplex/reject per op
// class from the permanent-fault map, drives the replica enables, retries
// DMR mismatches and reports done/error.
//
// state | meaning
// IDLE  | ready for a request; fault map sampled on acceptance
// BUSY  | selected units enabled, waiting for all of them to be ready
// RETRY | one dead cycle with enables low before re-running a DMR op
// DONE  | one-cycle done pulse; round-robin pointer advances
module cv32e40p_mult_sched_ft #(
  parameter int MAX_RETRY = 1,
  parameter int TIMEOUT   = 15
) (
  input logic                          clk,
  input logic                          rst,
  cv32e40p_mult_sched_ft_if.slave      bus
);

  typedef enum logic [1:0] {IDLE, BUSY, RETRY, DONE} state_e;

  localparam logic [1:0] MODE_TMR     = 2'd0;
  localparam logic [1:0] MODE_DMR     = 2'd1;
  localparam logic [1:0] MODE_SIMPLEX = 2'd2;
  localparam logic [1:0] MODE_NONE    = 2'd3;

  state_e      state_q, state_d;
  logic [2:0]  mask_q, mask_d;
  logic [1:0]  mode_q, mode_d;
  logic [1:0]  sel_q, sel_d;
  logic        err_q, err_d;
  logic [1:0]  rr_q, rr_d;
  logic [3:0]  retry_q, retry_d;
  logic [7:0]  tmo_q, tmo_d;
  logic [31:0] rcnt_q, rcnt_d;

  logic [2:0]  healthy;
  logic [1:0]  n_healthy;
  logic [1:0]  acc_mode;
  logic [1:0]  acc_sel;
  logic        complete;

  // Health of each replica for the requested class, and the resulting mode.
  // With exactly as many healthy units as the mode needs, the enable mask is
  // simply the healthy mask; only the forwarded unit depends on the rr scan.
  always_comb begin
    for (int u = 0; u < 3; u++) begin
      healthy[u] = ~bus.permanent_faulty_mult_i[u*4 + int'(bus.req_class_i)];
    end
    n_healthy = {1'b0, healthy[0]} + {1'b0, healthy[1]} + {1'b0, healthy[2]};
    // 3 healthy -> TMR(0), 2 -> DMR(1), 1 -> SIMPLEX(2), 0 -> NONE(3)
    acc_mode  = 2'd3 - n_healthy;
  end

  // First healthy unit in the scan rr, rr+1, rr+2 (mod 3); TMR forwards unit 0.
  always_comb begin
    logic [2:0] idx;
    logic       found;
    acc_sel = 2'd0;
    found   = 1'b0;
    idx     = 3'd0;
    for (int k = 0; k < 3; k++) begin
      idx = {1'b0, rr_q} + 3'(k);
      if (idx >= 3'd3) idx = idx - 3'd3;
      if (!found && healthy[idx[1:0]]) begin
        acc_sel = idx[1:0];
        found   = 1'b1;
      end
    end
    if (n_healthy == 2'd3) acc_sel = 2'd0;
  end

  assign complete = ((bus.mult_ready_i & mask_q) == mask_q);

  // Next-state and output decode.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    mode_d  = mode_q;
    sel_d   = sel_q;
    err_d   = err_q;
    rr_d    = rr_q;
    retry_d = retry_q;
    tmo_d   = tmo_q;
    rcnt_d  = rcnt_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid_i) begin
          mask_d  = healthy;
          mode_d  = acc_mode;
          sel_d   = acc_sel;
          retry_d = 4'd0;
          tmo_d   = 8'd0;
          err_d   = (acc_mode == MODE_NONE);
          state_d = (acc_mode == MODE_NONE) ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (complete) begin
          if (mode_q == MODE_DMR && bus.mismatch_i) begin
            if (retry_q < 4'(MAX_RETRY)) begin
              retry_d = retry_q + 4'd1;
              rcnt_d  = (rcnt_q == 32'hFFFF_FFFF) ? rcnt_q : rcnt_q + 32'd1;
              state_d = RETRY;
            end else begin
              err_d   = 1'b1;
              state_d = DONE;
            end
          end else begin
            err_d   = 1'b0;
            state_d = DONE;
          end
        end else if (tmo_q == 8'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      RETRY: begin
        tmo_d   = 8'd0;
        state_d = BUSY;
      end
      DONE: begin
        if (mode_q == MODE_DMR || mode_q == MODE_SIMPLEX) begin
          rr_d = (rr_q == 2'd2) ? 2'd0 : rr_q + 2'd1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    bus.req_ready_o   = (state_q == IDLE);
    bus.mult_enable_o = (state_q == BUSY) ? mask_q : 3'b000;
    bus.done_o        = (state_q == DONE);
    bus.done_err_o    = (state_q == DONE) && err_q;
    bus.mode_o        = mode_q;
    bus.sel_o         = sel_q;
    bus.retry_count_o = rcnt_q;
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mask_q  <= 3'b000;
      mode_q  <= MODE_NONE;
      sel_q   <= 2'd0;
      err_q   <= 1'b0;
      rr_q    <= 2'd0;
      retry_q <= 4'd0;
      tmo_q   <= 8'd0;
      rcnt_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      mode_q  <= mode_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
      rr_q    <= rr_d;
      retry_q <= retry_d;
      tmo_q   <= tmo_d;
      rcnt_q  <= rcnt_d;
    end
  end

endmodule

// File: tb/tb_cv32e40p_mult_sched_ft.sv
// Bench for the fault-tolerant multiply scheduler: directed scenarios plus
// randomized back-to-back operations against a behavioural model.
module tb_cv32e40p_mult_sched_ft;
  localparam int MAX_RETRY = 1;
  localparam int TIMEOUT   = 15;
  localparam int NEVER     = 1000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  cv32e40p_mult_sched_ft_if bus ();

  cv32e40p_mult_sched_ft #(.MAX_RETRY(MAX_RETRY), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // model state and expectations
  int          model_rr = 0;
  logic [31:0] model_rc = 0;
  logic [1:0]  exp_mode, exp_sel;
  logic [2:0]  exp_mask;
  logic        exp_err;
  int          exp_en_cycles, exp_gaps, exp_lat;

  // observations of one operation
  logic        obs_ready_acc, obs_err, obs_done_next, obs_ready_next, obs_ready_busy;
  logic        obs_mask_bad, obs_timed_out;
  logic [1:0]  obs_mode, obs_sel;
  logic [2:0]  obs_mask;
  int          obs_en_cycles, obs_gaps, obs_lat;
  logic [31:0] obs_rc;

  // Behavioural model: mode from healthy count, enables = healthy units,
  // forwarded unit = first healthy going round from rr; attempt timing from d.
  task automatic model_op(input logic [11:0] pf, input logic [1:0] cls, input int d,
                          input logic [1:0] mm);
    int n, busy, gaps;
    logic [2:0] h;
    h = 3'b000; n = 0;
    for (int u = 0; u < 3; u++) if (pf[u*4 + int'(cls)] == 1'b0) begin h[u] = 1'b1; n++; end
    case (n)
      3: exp_mode = 2'd0;
      2: exp_mode = 2'd1;
      1: exp_mode = 2'd2;
      default: exp_mode = 2'd3;
    endcase
    exp_mask = h;
    exp_sel = 2'd0;
    if (n == 1 || n == 2)
      for (int k = 2; k >= 0; k--) if (h[(model_rr + k) % 3]) exp_sel = 2'((model_rr + k) % 3);
    busy = 0; gaps = 0; exp_err = (n == 0);
    if (n != 0) begin
      for (int a = 0; a <= MAX_RETRY; a++) begin
        if (d + 1 > TIMEOUT) begin busy += TIMEOUT; exp_err = 1'b1; break; end
        busy += d + 1;
        if (!(n == 2 && mm[a])) break;
        if (a == MAX_RETRY) begin exp_err = 1'b1; break; end
        gaps++;
      end
    end
    exp_en_cycles = busy;
    exp_gaps = gaps;
    exp_lat = busy + gaps + 1;
    model_rc = model_rc + 32'(gaps);
    if (n == 1 || n == 2) model_rr = (model_rr + 1) % 3;
  endtask

  // Drives one request from a negedge in IDLE, plays the MULT units (all
  // enabled units ready d+1 cycles into each run) and records what happens.
  // Returns at the negedge of the idle cycle following the done pulse.
  task automatic do_op(input logic [11:0] pf, input logic [1:0] cls, input int d,
                       input logic [1:0] mm, input bit hold, input bit scramble);
    int en_run, run;
    logic [2:0] en, r;
    bit done_seen;
    bus.req_valid_i = 1'b1;
    bus.req_class_i = cls;
    bus.permanent_faulty_mult_i = pf;
    bus.mult_ready_i = 3'b000;
    bus.mismatch_i = 1'b0;
    obs_ready_acc = bus.req_ready_o;
    obs_mask = 3'b000; obs_mask_bad = 1'b0; obs_en_cycles = 0; obs_gaps = 0;
    obs_lat = -1; obs_err = 1'bx; obs_ready_busy = 1'b0; obs_mode = 2'bxx; obs_sel = 2'bxx;
    en_run = 0; run = 0; done_seen = 0;
    @(posedge clk);
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (!hold) bus.req_valid_i = 1'b0;
      else bus.req_class_i = 2'($urandom);
      if (scramble) bus.permanent_faulty_mult_i = 12'($urandom);
      if (c == 1) begin obs_mode = bus.mode_o; obs_sel = bus.sel_o; end
      if (bus.req_ready_o) obs_ready_busy = 1'b1;
      if (bus.done_o) begin
        obs_lat = c; obs_err = bus.done_err_o; done_seen = 1; break;
      end
      en = bus.mult_enable_o;
      if (en != 3'b000) begin
        if (en_run == 0) run++;
        if (obs_mask == 3'b000) obs_mask = en;
        else if (en != obs_mask) obs_mask_bad = 1'b1;
        en_run++; obs_en_cycles++;
        if (en_run >= d + 1) r = 3'b111;
        else begin r = 3'($urandom); r = r & ~(en & ~(en - 3'd1)); end
        bus.mult_ready_i = r;
        bus.mismatch_i = (run <= 2) ? mm[run-1] : 1'b1;
      end else begin
        if (obs_mask != 3'b000) obs_gaps++;
        en_run = 0;
        bus.mult_ready_i = 3'($urandom);
        bus.mismatch_i = 1'($urandom);
      end
    end
    obs_timed_out = !done_seen;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    bus.mult_ready_i = 3'b000;
    obs_done_next = bus.done_o;
    obs_ready_next = bus.req_ready_o;
    obs_rc = bus.retry_count_o;
  endtask

  task automatic test_reset;
    bus.req_valid_i = 1'b0; bus.req_class_i = 2'd0; bus.permanent_faulty_mult_i = 12'h0;
    bus.mult_ready_i = 3'b000; bus.mismatch_i = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++; if (bus.req_ready_o !== 1'b1) begin n_err++; $display("FAIL reset ready: got %b want 1", bus.req_ready_o); end
    n_vec++; if (bus.mult_enable_o !== 3'b000) begin n_err++; $display("FAIL reset enable: got %b want 000", bus.mult_enable_o); end
    n_vec++; if (bus.mode_o !== 2'd3) begin n_err++; $display("FAIL reset mode: got %0d want 3", bus.mode_o); end
    n_vec++; if (bus.sel_o !== 2'd0) begin n_err++; $display("FAIL reset sel: got %0d want 0", bus.sel_o); end
    n_vec++; if ({bus.done_o, bus.done_err_o} !== 2'b00) begin n_err++; $display("FAIL reset done: got %b want 00", {bus.done_o, bus.done_err_o}); end
    n_vec++; if (bus.retry_count_o !== 32'd0) begin n_err++; $display("FAIL reset retry_count: got %0d want 0", bus.retry_count_o); end
    rst = 1'b0;
  endtask

  task automatic test_tmr;
    model_op(12'h000, 2'd1, 3, 2'b00);
    do_op(12'h000, 2'd1, 3, 2'b00, 0, 0);
    n_vec++; if (obs_mode !== 2'd0) begin n_err++; $display("FAIL tmr mode: got %0d want 0", obs_mode); end
    n_vec++; if (obs_mask !== 3'b111) begin n_err++; $display("FAIL tmr enable: got %b want 111", obs_mask); end
    n_vec++; if (obs_lat !== 5 || obs_lat !== exp_lat) begin n_err++; $display("FAIL tmr latency: got %0d want %0d", obs_lat, exp_lat); end
    n_vec++; if (obs_err !== 1'b0) begin n_err++; $display("FAIL tmr err: got %b want 0", obs_err); end
    n_vec++; if (obs_done_next !== 1'b0) begin n_err++; $display("FAIL tmr done width: got %b want 0", obs_done_next); end
  endtask

  task automatic test_dmr_rr;
    for (int i = 0; i < 2; i++) begin
      model_op(12'h004, 2'd2, 1, 2'b00);
      do_op(12'h004, 2'd2, 1, 2'b00, 0, i == 1);
      n_vec++; if (obs_mode !== 2'd1) begin n_err++; $display("FAIL dmr%0d mode: got %0d want 1", i, obs_mode); end
      n_vec++; if (obs_mask !== 3'b110) begin n_err++; $display("FAIL dmr%0d enable: got %b want 110", i, obs_mask); end
      n_vec++; if (obs_sel !== 2'd1 || obs_sel !== exp_sel) begin n_err++; $display("FAIL dmr%0d sel: got %0d want %0d", i, obs_sel, exp_sel); end
      n_vec++; if (obs_err !== 1'b0 || obs_lat !== exp_lat) begin n_err++; $display("FAIL dmr%0d done: got err=%b lat=%0d want err=0 lat=%0d", i, obs_err, obs_lat, exp_lat); end
    end
  endtask

  task automatic test_dmr_retry;
    model_op(12'h100, 2'd0, 1, 2'b11);
    do_op(12'h100, 2'd0, 1, 2'b11, 0, 0);
    n_vec++; if (obs_mask !== 3'b011 || obs_sel !== exp_sel) begin n_err++; $display("FAIL retry select: got mask=%b sel=%0d want mask=011 sel=%0d", obs_mask, obs_sel, exp_sel); end
    n_vec++; if (obs_gaps !== 1) begin n_err++; $display("FAIL retry gap cycles: got %0d want 1", obs_gaps); end
    n_vec++; if (obs_err !== 1'b1 || obs_lat !== exp_lat) begin n_err++; $display("FAIL retry done: got err=%b lat=%0d want err=1 lat=%0d", obs_err, obs_lat, exp_lat); end
    n_vec++; if (obs_rc !== 32'd1) begin n_err++; $display("FAIL retry count: got %0d want 1", obs_rc); end
  endtask

  task automatic test_reject;
    model_op(12'h888, 2'd3, 0, 2'b00);
    do_op(12'h888, 2'd3, 0, 2'b00, 0, 0);
    n_vec++; if (obs_en_cycles !== 0) begin n_err++; $display("FAIL reject enables: got %0d cycles want 0", obs_en_cycles); end
    n_vec++; if (obs_lat !== 1 || obs_err !== 1'b1) begin n_err++; $display("FAIL reject done: got lat=%0d err=%b want lat=1 err=1", obs_lat, obs_err); end
    n_vec++; if (obs_mode !== 2'd3) begin n_err++; $display("FAIL reject mode: got %0d want 3", obs_mode); end
  endtask

  task automatic test_timeout;
    model_op(12'h202, 2'd1, NEVER, 2'b00);
    do_op(12'h202, 2'd1, NEVER, 2'b00, 0, 0);
    n_vec++; if (obs_mask !== 3'b010 || obs_mask_bad !== 1'b0) begin n_err++; $display("FAIL timeout enable: got %b (changed=%b) want 010", obs_mask, obs_mask_bad); end
    n_vec++; if (obs_en_cycles !== TIMEOUT) begin n_err++; $display("FAIL timeout busy cycles: got %0d want %0d", obs_en_cycles, TIMEOUT); end
    n_vec++; if (obs_err !== 1'b1 || obs_lat !== exp_lat) begin n_err++; $display("FAIL timeout done: got err=%b lat=%0d want err=1 lat=%0d", obs_err, obs_lat, exp_lat); end
  endtask

  task automatic test_reset_midop;
    bit done_seen;
    bus.req_valid_i = 1'b1; bus.req_class_i = 2'd1; bus.permanent_faulty_mult_i = 12'h000;
    bus.mult_ready_i = 3'b000;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++; if (bus.mult_enable_o !== 3'b111) begin n_err++; $display("FAIL midop busy enable: got %b want 111", bus.mult_enable_o); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_vec++; if (bus.mult_enable_o !== 3'b000 || bus.req_ready_o !== 1'b1) begin n_err++; $display("FAIL midop reset: got enable=%b ready=%b want 000/1", bus.mult_enable_o, bus.req_ready_o); end
    n_vec++; if (bus.retry_count_o !== 32'd0 || bus.mode_o !== 2'd3) begin n_err++; $display("FAIL midop regs: got rc=%0d mode=%0d want 0/3", bus.retry_count_o, bus.mode_o); end
    done_seen = 0;
    for (int c = 0; c < 20; c++) begin
      bus.mult_ready_i = 3'b111;
      if (bus.done_o) done_seen = 1;
      @(negedge clk);
    end
    bus.mult_ready_i = 3'b000;
    n_vec++; if (done_seen !== 1'b0) begin n_err++; $display("FAIL midop dropped op: got done=%b want 0", done_seen); end
    model_rr = 0;
    model_rc = 0;
  endtask

  task automatic test_random_back_to_back;
    logic [11:0] pf;
    logic [1:0]  cls, mm;
    int d;
    for (int i = 0; i < 40; i++) begin
      cls = 2'($urandom);
      case ($urandom_range(0, 3))
        0: pf = 12'h000;
        1: pf = 12'($urandom) & 12'($urandom);
        2: pf = 12'($urandom);
        default: pf = 12'($urandom) | 12'($urandom);
      endcase
      d = ($urandom_range(0, 7) == 0) ? 30 : $urandom_range(0, 5);
      mm = 2'($urandom);
      model_op(pf, cls, d, mm);
      do_op(pf, cls, d, mm, 1'($urandom), 1'($urandom));
      n_vec++; if (obs_timed_out !== 1'b0 || obs_ready_acc !== 1'b1) begin n_err++; $display("FAIL rnd%0d handshake: got no_done=%b ready=%b want 0/1", i, obs_timed_out, obs_ready_acc); end
      n_vec++; if (obs_mode !== exp_mode || obs_sel !== exp_sel) begin n_err++; $display("FAIL rnd%0d mode/sel: got %0d/%0d want %0d/%0d", i, obs_mode, obs_sel, exp_mode, exp_sel); end
      n_vec++; if (obs_mask !== ((exp_mode == 2'd3) ? 3'b000 : exp_mask) || obs_mask_bad !== 1'b0) begin n_err++; $display("FAIL rnd%0d enable: got %b (changed=%b) want %b", i, obs_mask, obs_mask_bad, exp_mask); end
      n_vec++; if (obs_en_cycles !== exp_en_cycles || obs_gaps !== exp_gaps) begin n_err++; $display("FAIL rnd%0d busy/retry cycles: got %0d/%0d want %0d/%0d", i, obs_en_cycles, obs_gaps, exp_en_cycles, exp_gaps); end
      n_vec++; if (obs_lat !== exp_lat || obs_err !== exp_err) begin n_err++; $display("FAIL rnd%0d done: got lat=%0d err=%b want lat=%0d err=%b", i, obs_lat, obs_err, exp_lat, exp_err); end
      n_vec++; if (obs_ready_busy !== 1'b0 || obs_done_next !== 1'b0 || obs_ready_next !== 1'b1) begin n_err++; $display("FAIL rnd%0d ready/done pulse: got busy_ready=%b next_done=%b next_ready=%b want 0/0/1", i, obs_ready_busy, obs_done_next, obs_ready_next); end
      n_vec++; if (obs_rc !== model_rc) begin n_err++; $display("FAIL rnd%0d retry_count: got %0d want %0d", i, obs_rc, model_rc); end
    end
  endtask

  initial begin
    test_reset();
    test_tmr();
    test_dmr_rr();
    test_dmr_retry();
    test_reject();
    test_timeout();
    test_reset_midop();
    test_random_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
